// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side signals of the 2-way instruction cache.
// The slave modport is the cache; the master modport is the fetcher/memory side.
interface icache_sa_if;
  logic        need_mem;
  logic [31:0] mem_addr;
  logic [31:0] mem_ins;
  logic        mem_ins_ready;
  logic        fetch_able;
  logic [31:0] input_pc;
  logic        flush;
  logic        hit;
  logic [31:0] hit_ins;
  logic [31:0] ins_pc;

  modport slave (
    input  mem_ins, mem_ins_ready, fetch_able, input_pc, flush,
    output need_mem, mem_addr, hit, hit_ins, ins_pc
  );

  modport master (
    output mem_ins, mem_ins_ready, fetch_able, input_pc, flush,
    input  need_mem, mem_addr, hit, hit_ins, ins_pc
  );
endinterface

// File: rtl/icache_sa.sv
// 2-way set-associative instruction cache with a zero-latency lookup and
// word-by-word line fill that forwards received/arriving words to the fetcher.
module icache_sa #(
  parameter int ADDR_WIDTH  = 18,
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  icache_sa_if.slave  bus
);
  localparam int TAG_W  = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS - 2;
  localparam int LINE_W = ADDR_WIDTH - OFFSET_BITS - 2;
  localparam int SETS   = 1 << INDEX_BITS;
  localparam int WORDS  = 1 << OFFSET_BITS;
  localparam logic [OFFSET_BITS-1:0] LAST = OFFSET_BITS'(WORDS - 1);

  typedef enum logic {IDLE, FILL} state_e;

  state_e                  state_q, state_d;
  logic                    need_q, need_d;
  logic [31:0]             addr_q, addr_d;
  logic [OFFSET_BITS-1:0]  cnt_q, cnt_d;
  logic [WORDS-1:0]        mask_q, mask_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic                    vict_q, vict_d;

  logic [1:0][SETS-1:0]    valid_q;
  logic [SETS-1:0]         lru_q;
  logic [TAG_W-1:0]        tag_q  [2][SETS];
  logic [31:0]             data_q [2][SETS][WORDS];

  logic [LINE_W-1:0]       pc_line;
  logic [INDEX_BITS-1:0]   pc_idx, f_idx;
  logic [TAG_W-1:0]        pc_tag, f_tag;
  logic [OFFSET_BITS-1:0]  pc_word;
  logic                    hit0, hit1, way_hit, hit_way, victim;
  logic                    in_line, arriving, fwd;
  logic                    start_fill, wr_word, fill_done, lru_touch;

  assign pc_line = bus.input_pc[ADDR_WIDTH-1:OFFSET_BITS+2];
  assign pc_idx  = pc_line[INDEX_BITS-1:0];
  assign pc_tag  = pc_line[LINE_W-1:INDEX_BITS];
  assign pc_word = bus.input_pc[OFFSET_BITS+1:2];
  assign f_idx   = line_q[INDEX_BITS-1:0];
  assign f_tag   = line_q[LINE_W-1:INDEX_BITS];

  assign hit0    = valid_q[0][pc_idx] && (tag_q[0][pc_idx] == pc_tag);
  assign hit1    = valid_q[1][pc_idx] && (tag_q[1][pc_idx] == pc_tag);
  assign way_hit = hit0 | hit1;
  assign hit_way = hit1;
  assign victim  = !valid_q[0][pc_idx] ? 1'b0 :
                   !valid_q[1][pc_idx] ? 1'b1 : lru_q[pc_idx];

  // An arriving word beats the received mask so the fetcher sees it this cycle.
  assign in_line  = (state_q == FILL) && (pc_line == line_q);
  assign arriving = in_line && bus.mem_ins_ready && (addr_q[OFFSET_BITS+1:2] == pc_word);
  assign fwd      = arriving || (in_line && mask_q[pc_word]);

  assign bus.hit      = rdy_in && bus.fetch_able && !bus.flush && (way_hit || fwd);
  assign bus.hit_ins  = arriving ? bus.mem_ins
                                 : data_q[fwd ? vict_q : hit_way][pc_idx][pc_word];
  assign bus.ins_pc   = bus.input_pc;
  assign bus.need_mem = need_q;
  assign bus.mem_addr = addr_q;

  always_comb begin
    state_d    = state_q;
    need_d     = need_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    line_d     = line_q;
    vict_d     = vict_q;
    start_fill = 1'b0;
    wr_word    = 1'b0;
    fill_done  = 1'b0;
    lru_touch  = 1'b0;
    if (rdy_in) begin
      if (bus.flush) begin
        state_d = IDLE;
        need_d  = 1'b0;
        addr_d  = '0;
      end else begin
        unique case (state_q)
          IDLE: if (bus.fetch_able) begin
            if (way_hit) begin
              lru_touch = 1'b1;
            end else begin
              state_d    = FILL;
              start_fill = 1'b1;
              line_d     = pc_line;
              vict_d     = victim;
              need_d     = 1'b1;
              addr_d     = {bus.input_pc[31:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
              cnt_d      = '0;
              mask_d     = '0;
            end
          end
          FILL: if (bus.mem_ins_ready) begin
            wr_word       = 1'b1;
            mask_d[cnt_q] = 1'b1;
            cnt_d         = cnt_q + 1'b1;
            addr_d        = addr_q + 32'd4;
            if (cnt_q == LAST) begin
              fill_done = 1'b1;
              state_d   = IDLE;
              need_d    = 1'b0;
              addr_d    = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      need_q  <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      line_q  <= '0;
      vict_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      need_q  <= need_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      line_q  <= line_d;
      vict_q  <= vict_d;
    end
  end

  // Victim stays invalid for the whole fill so a partial line never way-hits.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else if (rdy_in && bus.flush) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      if (start_fill) valid_q[victim][pc_idx] <= 1'b0;
      if (lru_touch)  lru_q[pc_idx] <= ~hit_way;
      if (fill_done) begin
        valid_q[vict_q][f_idx] <= 1'b1;
        lru_q[f_idx]           <= ~vict_q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      if (wr_word)   data_q[vict_q][f_idx][cnt_q] <= bus.mem_ins;
      if (fill_done) tag_q[vict_q][f_idx]         <= f_tag;
    end
  end
endmodule

// File: tb/tb_icache_sa.sv
// Bench for icache_sa: directed scenarios plus randomized traffic checked
// against a line-level model of resident lines, LRU and the in-flight fill.
module tb_icache_sa;
  logic clk = 1'b0;
  logic rst, rdy;
  always #5 clk = ~clk;

  icache_sa_if bus();
  icache_sa dut (.clk_in(clk), .rst_in(rst), .rdy_in(rdy), .bus(bus));

  int n_chk = 0, n_pass = 0;

  bit          m_val  [2][64];
  logic [13:0] m_line [2][64];
  bit          m_lru  [64];
  bit          f_act;
  logic [13:0] f_line;
  int          f_n, f_way;
  logic [31:0] f_base;

  logic        o_hit, o_need;
  logic [31:0] o_ins, o_addr, o_pc;
  bit          e_hit, e_need;
  logic [31:0] e_ins, e_addr;

  function automatic logic [31:0] memfun(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic int res_way(input logic [31:0] pc);
    int s = int'(pc[9:4]);
    for (int w = 0; w < 2; w++)
      if (m_val[w][s] && m_line[w][s] == pc[17:4]) return w;
    return -1;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 64; s++) begin
      m_val[0][s] = 0; m_val[1][s] = 0; m_lru[s] = 0;
    end
    f_act = 0; f_n = 0;
  endtask

  // One clock: drive inputs, sample outputs and model expectations, advance model.
  task automatic step(input bit fe, input logic [31:0] pc, input bit fl,
                      input bit rd, input bit rs, input bit mr);
    int s, w, wd, v;
    bit fwd;
    @(negedge clk);
    bus.fetch_able = fe; bus.input_pc = pc; bus.flush = fl;
    rdy = rd; rst = rs; bus.mem_ins_ready = mr;
    bus.mem_ins = memfun(bus.mem_addr);
    #1;
    o_hit = bus.hit; o_ins = bus.hit_ins; o_need = bus.need_mem;
    o_addr = bus.mem_addr; o_pc = bus.ins_pc;
    s = int'(pc[9:4]); wd = int'(pc[3:2]); w = res_way(pc);
    fwd    = f_act && pc[17:4] == f_line && (wd < f_n || (mr && wd == f_n));
    e_hit  = rd && fe && !fl && (w >= 0 || fwd);
    e_ins  = memfun({pc[31:2], 2'b00});
    e_need = f_act;
    e_addr = f_act ? f_base + 32'(4 * f_n) : 32'h0;
    @(posedge clk);
    if (rs) model_clear();
    else if (rd) begin
      if (fl) model_clear();
      else if (!f_act) begin
        if (fe && w < 0) begin
          v = !m_val[0][s] ? 0 : !m_val[1][s] ? 1 : int'(m_lru[s]);
          m_val[v][s] = 0;
          f_act = 1; f_line = pc[17:4]; f_way = v; f_n = 0; f_base = {pc[31:4], 4'h0};
        end else if (fe) m_lru[s] = (w == 0);
      end else if (mr) begin
        f_n++;
        if (f_n == 4) begin
          s = int'(f_line[5:0]);
          m_val[f_way][s] = 1; m_line[f_way][s] = f_line; m_lru[s] = (f_way == 0);
          f_act = 0;
        end
      end
    end
  endtask

  task automatic do_reset(); step(0, 32'h0, 0, 1, 1, 0); endtask

  task automatic fill_line(input logic [31:0] pc);
    step(1, pc, 0, 1, 0, 0);
    for (int i = 0; i < 8 && f_act; i++) step(1, pc, 0, 1, 0, 1);
  endtask

  task automatic test_reset();
    do_reset();
    step(1, 32'h100, 0, 1, 0, 0);
    n_chk++; if (o_need !== 1'b0) $display("FAIL reset_need got=%0b exp=0", o_need); else n_pass++;
    n_chk++; if (o_addr !== 32'h0) $display("FAIL reset_addr got=%h exp=0", o_addr); else n_pass++;
    n_chk++; if (o_hit !== 1'b0) $display("FAIL reset_hit got=%0b exp=0", o_hit); else n_pass++;
  endtask

  task automatic test_cold_miss();
    logic [31:0] a;
    do_reset();
    step(1, 32'h100, 0, 1, 0, 0);
    n_chk++; if (o_hit !== 1'b0) $display("FAIL cold_first_hit got=%0b exp=0", o_hit); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      a = 32'h100 + 32'(4 * i);
      step(1, a, 0, 1, 0, 1);
      n_chk++; if (o_need !== 1'b1) $display("FAIL cold_need[%0d] got=%0b exp=1", i, o_need); else n_pass++;
      n_chk++; if (o_addr !== a) $display("FAIL cold_addr[%0d] got=%h exp=%h", i, o_addr, a); else n_pass++;
      n_chk++; if (o_hit !== 1'b1 || o_ins !== memfun(a))
        $display("FAIL cold_fwd[%0d] got=%0b/%h exp=1/%h", i, o_hit, o_ins, memfun(a)); else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      a = 32'h100 + 32'(4 * i);
      step(1, a, 0, 1, 0, 0);
      n_chk++; if (o_hit !== 1'b1 || o_ins !== memfun(a) || o_need !== 1'b0)
        $display("FAIL cold_rehit[%0d] got=%0b/%h/%0b exp=1/%h/0", i, o_hit, o_ins, o_need, memfun(a)); else n_pass++;
    end
  endtask

  task automatic test_conflict();
    do_reset();
    fill_line(32'h000); fill_line(32'h400); fill_line(32'h800);
    step(1, 32'h404, 0, 1, 0, 0);
    n_chk++; if (o_hit !== 1'b1 || o_ins !== memfun(32'h404))
      $display("FAIL conflict_keep got=%0b/%h exp=1/%h", o_hit, o_ins, memfun(32'h404)); else n_pass++;
    step(1, 32'h808, 0, 1, 0, 0);
    n_chk++; if (o_hit !== 1'b1) $display("FAIL conflict_new got=%0b exp=1", o_hit); else n_pass++;
    step(1, 32'h000, 0, 1, 0, 0);
    n_chk++; if (o_hit !== 1'b0) $display("FAIL conflict_evict got=%0b exp=0", o_hit); else n_pass++;
  endtask

  task automatic test_lru();
    do_reset();
    fill_line(32'h000); fill_line(32'h400);
    step(1, 32'h000, 0, 1, 0, 0);
    n_chk++; if (o_hit !== 1'b1) $display("FAIL lru_touch got=%0b exp=1", o_hit); else n_pass++;
    fill_line(32'h800);
    step(1, 32'h00C, 0, 1, 0, 0);
    n_chk++; if (o_hit !== 1'b1 || o_ins !== memfun(32'h00C))
      $display("FAIL lru_keep got=%0b/%h exp=1/%h", o_hit, o_ins, memfun(32'h00C)); else n_pass++;
    step(1, 32'h400, 0, 1, 0, 0);
    n_chk++; if (o_hit !== 1'b0) $display("FAIL lru_evict got=%0b exp=0", o_hit); else n_pass++;
  endtask

  task automatic test_flush_midfill();
    do_reset();
    step(1, 32'h200, 0, 1, 0, 0);
    step(1, 32'h200, 0, 1, 0, 1);
    step(1, 32'h204, 0, 1, 0, 1);
    step(1, 32'h208, 1, 1, 0, 1);
    n_chk++; if (o_hit !== 1'b0) $display("FAIL flush_hit got=%0b exp=0", o_hit); else n_pass++;
    step(0, 32'h200, 0, 1, 0, 0);
    n_chk++; if (o_need !== 1'b0 || o_addr !== 32'h0)
      $display("FAIL flush_abort got=%0b/%h exp=0/0", o_need, o_addr); else n_pass++;
    step(1, 32'h200, 0, 1, 0, 0);
    n_chk++; if (o_hit !== 1'b0) $display("FAIL flush_refetch got=%0b exp=0", o_hit); else n_pass++;
    step(1, 32'h200, 0, 1, 0, 0);
    n_chk++; if (o_need !== 1'b1 || o_addr !== 32'h200)
      $display("FAIL flush_restart got=%0b/%h exp=1/200", o_need, o_addr); else n_pass++;
    for (int i = 0; i < 8 && f_act; i++) step(1, 32'h200, 0, 1, 0, 1);
    // flush coinciding with the last word must not validate the line
    step(1, 32'h30C, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h300, 0, 1, 0, 1);
    step(1, 32'h30C, 1, 1, 0, 1);
    step(1, 32'h30C, 0, 1, 0, 0);
    n_chk++; if (o_hit !== 1'b0 || o_need !== 1'b0)
      $display("FAIL flush_last got=%0b/%0b exp=0/0", o_hit, o_need); else n_pass++;
    step(0, 32'h30C, 0, 1, 0, 0);
    n_chk++; if (o_need !== 1'b1 || o_addr !== 32'h300)
      $display("FAIL flush_last_restart got=%0b/%h exp=1/300", o_need, o_addr); else n_pass++;
  endtask

  task automatic test_rdy_stall();
    logic [31:0] a;
    do_reset();
    step(1, 32'h500, 0, 1, 0, 0);
    step(1, 32'h500, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h500, 0, 0, 0, 1);
      n_chk++; if (o_hit !== 1'b0 || o_need !== 1'b1 || o_addr !== 32'h504)
        $display("FAIL stall[%0d] got=%0b/%0b/%h exp=0/1/504", i, o_hit, o_need, o_addr); else n_pass++;
    end
    for (int i = 0; i < 3; i++) step(1, 32'h500, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      a = 32'h500 + 32'(4 * i);
      step(1, a, 0, 1, 0, 0);
      n_chk++; if (o_hit !== 1'b1 || o_ins !== memfun(a))
        $display("FAIL stall_resume[%0d] got=%0b/%h exp=1/%h", i, o_hit, o_ins, memfun(a)); else n_pass++;
    end
  endtask

  task automatic test_reset_midfill();
    do_reset();
    fill_line(32'h100);
    step(1, 32'h600, 0, 1, 0, 0);
    step(1, 32'h600, 0, 1, 0, 1);
    step(1, 32'h604, 0, 1, 0, 1);
    step(1, 32'h608, 0, 1, 1, 1);
    step(1, 32'h100, 0, 1, 0, 0);
    n_chk++; if (o_need !== 1'b0 || o_addr !== 32'h0)
      $display("FAIL rstfill_idle got=%0b/%h exp=0/0", o_need, o_addr); else n_pass++;
    n_chk++; if (o_hit !== 1'b0) $display("FAIL rstfill_miss got=%0b exp=0", o_hit); else n_pass++;
    step(1, 32'h608, 0, 1, 0, 0);
    n_chk++; if (o_need !== 1'b1 || o_addr !== 32'h100)
      $display("FAIL rstfill_refill got=%0b/%h exp=1/100", o_need, o_addr); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] pc;
    bit fe, fl, rd, rs, mr;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 2)) << 4)
         | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      fe = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 49) == 0);
      rd = ($urandom_range(0, 7) != 0);
      rs = ($urandom_range(0, 299) == 0);
      mr = $urandom_range(0, 1) == 1;
      step(fe, pc, fl, rd, rs, mr);
      n_chk++; if (o_hit !== e_hit) $display("FAIL rnd_hit c=%0d pc=%h got=%0b exp=%0b", c, pc, o_hit, e_hit); else n_pass++;
      if (e_hit) begin
        n_chk++; if (o_ins !== e_ins) $display("FAIL rnd_ins c=%0d pc=%h got=%h exp=%h", c, pc, o_ins, e_ins); else n_pass++;
      end
      n_chk++; if (o_need !== e_need) $display("FAIL rnd_need c=%0d got=%0b exp=%0b", c, o_need, e_need); else n_pass++;
      n_chk++; if (o_addr !== e_addr) $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, o_addr, e_addr); else n_pass++;
      n_chk++; if (o_pc !== pc) $display("FAIL rnd_inspc c=%0d got=%h exp=%h", c, o_pc, pc); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    bus.fetch_able = 1'b0; bus.input_pc = '0; bus.flush = 1'b0;
    bus.mem_ins_ready = 1'b0; bus.mem_ins = '0;
    model_clear();
    test_reset();
    test_cold_miss();
    test_conflict();
    test_lru();
    test_flush_midfill();
    test_rdy_stall();
    test_reset_midfill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
